curr_setpt_seq: RTL and testbench
=================================

// Module: curr_setpt_seq
// PURPOSE
//  Sequences the target_curr setpoint fed to the PID current loop.
//  - Ramps target_curr toward a commanded value at a fixed slew, so the loop never sees a step (soft start/stop).
//  - Monitors avg_curr from the plant; on sustained overcurrent it latches a fault and forces the setpoint to 0.
//  - Sits between the command source and PID.target_curr; its avg_curr input is the same signal the PID consumes.
// PARAMETERS
//  STEP        12'h004  setpoint increment/decrement applied per ramp tick
//  TICK_DIV    16       clocks per ramp tick (>=2)
//  OC_LIMIT    12'hE00  overcurrent threshold on avg_curr (strictly greater trips)
//  OC_CYCLES   64       consecutive over-limit clocks required to trip the fault
//  SETTLE_TOL  12'h020  |avg_curr - target_curr| at or below this counts as settled
// PORTS
//  clk          in   1   system clock; all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  en           in   1   1 = ramp toward latched goal; 0 = ramp toward 0
//  cmd_vld      in   1   1-clk strobe: latch cmd_curr as new goal
//  cmd_curr     in   12  commanded current, unsigned
//  clr_fault    in   1   1-clk strobe: request exit from FAULT
//  avg_curr     in   12  measured average plant current, unsigned
//  target_curr  out  12  setpoint to PID, registered
//  busy         out  1   1 while state==RAMP
//  settled      out  1   registered; 1 in HOLD with error within SETTLE_TOL
//  fault        out  1   1 while state==FAULT
// BEHAVIOUR
//  Reset: state=IDLE, goal=0, target_curr=0, tick_cnt=0, oc_cnt=0, busy=0, settled=0, fault=0.
//  eff_goal = en ? goal : 0.
//  Goal latch: goal<=cmd_curr on cmd_vld in IDLE/RAMP/HOLD. cmd_vld is ignored in FAULT.
//  Tick: tick_cnt counts 0..TICK_DIV-1 and is cleared on every RAMP entry.
//    tick = (tick_cnt==TICK_DIV-1) while in RAMP; first step lands TICK_DIV clocks after entry.
//  States:
//   IDLE:  target_curr==0. eff_goal!=0 -> RAMP.
//   RAMP:  on tick, up:   target_curr <= min(target_curr+STEP, eff_goal);
//                   down: target_curr <= max(target_curr-STEP, eff_goal).
//          Compute in 13 bits; never wraps past 12'hFFF or below 0.
//          target_curr==eff_goal (evaluated each clk) -> HOLD if eff_goal!=0, else IDLE.
//          A goal change mid-ramp (incl. direction reversal) takes effect on the next tick; no tick_cnt restart.
//   HOLD:  target_curr constant. eff_goal!=target_curr -> RAMP.
//   FAULT: target_curr<=0 on entry clk. goal<=0. fault=1.
//          clr_fault && avg_curr<=OC_LIMIT -> IDLE.
//          clr_fault while avg_curr>OC_LIMIT is ignored.
//  OC detect (all states except FAULT): oc_cnt++ while avg_curr>OC_LIMIT (saturating), else oc_cnt<=0.
//    oc_cnt reaching OC_CYCLES -> FAULT on the next clk.
//    oc_cnt is cleared in FAULT.
//  Priority on the same clk: fault entry > cmd_vld > ramp step.
//  settled<=(state==HOLD)&&(|avg_curr-target_curr|<=SETTLE_TOL); the difference is computed signed in 13 bits.
//    settled is forced 0 in every other state.
//  busy and fault are decoded from the state register (glitch-free, no extra latency).
//  Async reset mid-ramp: all outputs return to reset values immediately. No ramp resumes until a new cmd_vld.
// TESTING
//  1 Reset with avg_curr=0 -> all outputs 0, state IDLE; hold 100 clk, target_curr stays 0.
//  2 en=1, cmd_curr=12'h800 strobe -> busy=1; target_curr +4 every 16 clk;
//    reaches 12'h800 after 512 ticks (~8192 clk), then HOLD, busy=0.
//  3 Closed loop with PID+plant, same as 2 -> settled=1 within 5000 clk of reaching HOLD;
//    no avg_curr overshoot > OC_LIMIT.
//  4 Mid-ramp at target 12'h400, cmd_curr=12'h100 -> target decrements by 4/tick to 12'h100, HOLD.
//    Then en=0 -> ramps to 0, IDLE.
//  5 Force avg_curr=12'hE01 for 63 clk -> no fault; for 64 clk -> fault=1 next clk, target_curr=0.
//    clr_fault with avg_curr high ignored; with avg_curr=0 -> IDLE.
//  6 STEP saturation: target 12'hFFE, goal 12'hFFF -> target 12'hFFF exactly, no wrap.
//    Assert rst_n=0 mid-ramp -> outputs 0 asynchronously.

Source files
------------

// File: rtl/curr_setpt_seq.sv
// Current setpoint sequencer.
// Ramps target_curr toward the commanded goal at a fixed slew so the PID loop
// never sees a step. It also watches avg_curr for sustained overcurrent, which
// latches a fault and forces the setpoint to zero.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   en           1 = ramp toward the latched goal, 0 = ramp toward 0
//   cmd_vld      1-clk strobe that latches cmd_curr as the new goal
//   cmd_curr     commanded current, unsigned 12 bit
//   clr_fault    1-clk strobe that requests exit from FAULT
//   avg_curr     measured average plant current, unsigned 12 bit
//   target_curr  registered setpoint to the PID loop
//   busy         1 while ramping
//   settled      1 in HOLD when |avg_curr - target_curr| is within SETTLE_TOL
//   fault        1 while the overcurrent fault is latched
module curr_setpt_seq #(
    parameter logic [11:0] STEP       = 12'h004,
    parameter int unsigned TICK_DIV   = 16,
    parameter logic [11:0] OC_LIMIT   = 12'hE00,
    parameter int unsigned OC_CYCLES  = 64,
    parameter logic [11:0] SETTLE_TOL = 12'h020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cmd_vld,
    input  logic [11:0] cmd_curr,
    input  logic        clr_fault,
    input  logic [11:0] avg_curr,
    output logic [11:0] target_curr,
    output logic        busy,
    output logic        settled,
    output logic        fault
);

    localparam int unsigned CW = 12;
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned OW = $clog2(OC_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] goal_q, goal_d;
    logic [CW-1:0] target_q, target_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [OW-1:0] oc_q, oc_d;
    logic          busy_q, busy_d;
    logic          settled_q, settled_d;
    logic          fault_q, fault_d;

    logic [CW-1:0] eff_goal;
    logic          tick;
    logic          oc_over;
    logic          oc_trip;
    logic [CW:0]   up_sum;
    logic [CW:0]   dn_dif;
    logic [CW-1:0] step_up;
    logic [CW-1:0] step_dn;
    logic [CW:0]   err;
    logic [CW:0]   err_abs;

    // Ramp arithmetic in 13 bits so a step can neither wrap past 12'hFFF nor below 0.
    always_comb begin
        eff_goal = en ? goal_q : '0;
        tick     = (state_q == S_RAMP) && (tick_q == TW'(TICK_DIV - 1));
        oc_over  = (avg_curr > OC_LIMIT);
        oc_trip  = (state_q != S_FAULT) && (oc_q == OW'(OC_CYCLES));
        up_sum   = {1'b0, target_q} + {1'b0, STEP};
        dn_dif   = {1'b0, target_q} - {1'b0, STEP};
        step_up  = (up_sum > {1'b0, eff_goal}) ? eff_goal : up_sum[CW-1:0];
        // A borrow in bit 12 means the subtraction went below zero.
        step_dn  = (dn_dif[CW] || (dn_dif < {1'b0, eff_goal})) ? eff_goal : dn_dif[CW-1:0];
        err      = {1'b0, avg_curr} - {1'b0, target_q};
        err_abs  = err[CW] ? ((CW+1)'(0) - err) : err;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        goal_d   = goal_q;
        target_d = target_q;
        tick_d   = tick_q;
        oc_d     = oc_q;

        case (state_q)
            S_IDLE: begin
                target_d = '0;
                tick_d   = '0;
                if (cmd_vld) begin
                    goal_d = cmd_curr;
                end
                if (eff_goal != '0) begin
                    state_d = S_RAMP;
                end
            end
            S_RAMP: begin
                if (cmd_vld) begin
                    goal_d = cmd_curr;
                end
                tick_d = tick ? '0 : tick_q + TW'(1);
                if (target_q == eff_goal) begin
                    state_d = (eff_goal != '0) ? S_HOLD : S_IDLE;
                    tick_d  = '0;
                end else if (tick) begin
                    target_d = (target_q < eff_goal) ? step_up : step_dn;
                end
            end
            S_HOLD: begin
                tick_d = '0;
                if (cmd_vld) begin
                    goal_d = cmd_curr;
                end
                if (eff_goal != target_q) begin
                    state_d = S_RAMP;
                end
            end
            S_FAULT: begin
                goal_d   = '0;
                target_d = '0;
                tick_d   = '0;
                if (clr_fault && !oc_over) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Overcurrent counter saturates at the trip count; held clear in FAULT.
        if (state_q == S_FAULT) begin
            oc_d = '0;
        end else if (oc_over) begin
            oc_d = (oc_q == OW'(OC_CYCLES)) ? oc_q : oc_q + OW'(1);
        end else begin
            oc_d = '0;
        end

        // Fault entry overrides any goal latch or ramp step on the same clock.
        if (oc_trip) begin
            state_d  = S_FAULT;
            goal_d   = '0;
            target_d = '0;
            tick_d   = '0;
        end

        busy_d    = (state_d == S_RAMP);
        fault_d   = (state_d == S_FAULT);
        settled_d = (state_q == S_HOLD) && (err_abs <= {1'b0, SETTLE_TOL});
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            goal_q    <= '0;
            target_q  <= '0;
            tick_q    <= '0;
            oc_q      <= '0;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            goal_q    <= goal_d;
            target_q  <= target_d;
            tick_q    <= tick_d;
            oc_q      <= oc_d;
            busy_q    <= busy_d;
            settled_q <= settled_d;
            fault_q   <= fault_d;
        end
    end

    assign target_curr = target_q;
    assign busy        = busy_q;
    assign settled     = settled_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_curr_setpt_seq.sv
// Directed bench for curr_setpt_seq: expected outputs are queued when a
// stimulus step is driven and popped/compared when the step's cycles elapse.
module tb_curr_setpt_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cmd_vld;
    logic [11:0] cmd_curr;
    logic        clr_fault;
    logic [11:0] avg_curr;
    logic [11:0] target_curr;
    logic        busy;
    logic        settled;
    logic        fault;

    typedef struct packed {
        logic [11:0] tgt;
        logic        busy;
        logic        settled;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    curr_setpt_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cmd_vld    (cmd_vld),
        .cmd_curr   (cmd_curr),
        .clr_fault  (clr_fault),
        .avg_curr   (avg_curr),
        .target_curr(target_curr),
        .busy       (busy),
        .settled    (settled),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string fld, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [11:0] tgt, input logic b, input logic s, input logic f);
        exp_t e;
        e.tgt     = tgt;
        e.busy    = b;
        e.settled = s;
        e.fault   = f;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        e = sb.pop_front();
        cmp(tag, "target_curr", target_curr, e.tgt);
        cmp(tag, "busy", 12'(busy), 12'(e.busy));
        cmp(tag, "settled", 12'(settled), 12'(e.settled));
        cmp(tag, "fault", 12'(fault), 12'(e.fault));
    endtask

    // Queue the expectation, run n clocks, then compare.
    task automatic step(input int n, input logic [11:0] tgt, input logic b, input logic s,
                        input logic f, input string tag);
        push_exp(tgt, b, s, f);
        cyc(n);
        pop_check(tag);
    endtask

    task automatic strobe(input logic [11:0] v);
        cmd_vld  = 1'b1;
        cmd_curr = v;
        cyc(1);
        cmd_vld  = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        cmd_vld   = 1'b0;
        cmd_curr  = 12'h000;
        clr_fault = 1'b0;
        avg_curr  = 12'h000;

        // Reset state, then idle with nothing commanded
        #3;
        step(0, 12'h000, 1'b0, 1'b0, 1'b0, "rst_assert");
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(100, 12'h000, 1'b0, 1'b0, 1'b0, "rst_hold100");

        // Soft start to 12'h800
        en = 1'b1;
        strobe(12'h800);
        step(1,    12'h000, 1'b1, 1'b0, 1'b0, "up_enter");
        step(15,   12'h000, 1'b1, 1'b0, 1'b0, "up_no_early_step");
        step(1,    12'h004, 1'b1, 1'b0, 1'b0, "up_first_step");
        step(16,   12'h008, 1'b1, 1'b0, 1'b0, "up_second_step");
        step(8160, 12'h800, 1'b1, 1'b0, 1'b0, "up_reach");
        step(1,    12'h800, 1'b0, 1'b0, 1'b0, "up_hold");

        // Settled window around the held setpoint, both edges
        avg_curr = 12'h810; step(1, 12'h800, 1'b0, 1'b1, 1'b0, "settle_in");
        avg_curr = 12'h821; step(1, 12'h800, 1'b0, 1'b0, 1'b0, "settle_over_hi");
        avg_curr = 12'h820; step(1, 12'h800, 1'b0, 1'b1, 1'b0, "settle_edge_hi");
        avg_curr = 12'h7DF; step(1, 12'h800, 1'b0, 1'b0, 1'b0, "settle_over_lo");
        avg_curr = 12'h7E0; step(1, 12'h800, 1'b0, 1'b1, 1'b0, "settle_edge_lo");
        avg_curr = 12'h000; step(1, 12'h800, 1'b0, 1'b0, 1'b0, "settle_off");

        // Ramp down, reverse mid-ramp at 12'h400 without tick restart
        strobe(12'h100);
        step(1,    12'h800, 1'b1, 1'b0, 1'b0, "dn_enter");
        step(16,   12'h7FC, 1'b1, 1'b0, 1'b0, "dn_first_step");
        step(4080, 12'h400, 1'b1, 1'b0, 1'b0, "dn_mid");
        strobe(12'h410);
        step(15,   12'h404, 1'b1, 1'b0, 1'b0, "rev_first_step");
        step(48,   12'h410, 1'b1, 1'b0, 1'b0, "rev_reach");
        step(1,    12'h410, 1'b0, 1'b0, 1'b0, "rev_hold");
        strobe(12'h100);
        step(1,    12'h410, 1'b1, 1'b0, 1'b0, "dn2_enter");
        step(3136, 12'h100, 1'b1, 1'b0, 1'b0, "dn2_reach");
        step(1,    12'h100, 1'b0, 1'b0, 1'b0, "dn2_hold");

        // Disable: soft stop to zero, back to idle
        en = 1'b0;
        step(1,    12'h100, 1'b1, 1'b0, 1'b0, "off_enter");
        step(1024, 12'h000, 1'b1, 1'b0, 1'b0, "off_reach_zero");
        step(1,    12'h000, 1'b0, 1'b0, 1'b0, "off_idle");

        // Overcurrent: 63 clocks no trip, at-limit no trip, 64 clocks trips
        avg_curr = 12'hE01; step(63, 12'h000, 1'b0, 1'b0, 1'b0, "oc63_armed");
        avg_curr = 12'h000; step(2,  12'h000, 1'b0, 1'b0, 1'b0, "oc63_no_fault");
        avg_curr = 12'hE00; step(80, 12'h000, 1'b0, 1'b0, 1'b0, "oc_at_limit");
        avg_curr = 12'hE01; step(64, 12'h000, 1'b0, 1'b0, 1'b0, "oc64_count");
        step(1, 12'h000, 1'b0, 1'b0, 1'b1, "oc64_fault");
        clr_fault = 1'b1;
        cmd_vld   = 1'b1;
        cmd_curr  = 12'h300;
        step(1, 12'h000, 1'b0, 1'b0, 1'b1, "clr_ignored_hi");
        clr_fault = 1'b0;
        cmd_vld   = 1'b0;
        avg_curr  = 12'h000;
        step(3, 12'h000, 1'b0, 1'b0, 1'b1, "fault_holds");
        en        = 1'b1;
        clr_fault = 1'b1;
        step(1, 12'h000, 1'b0, 1'b0, 1'b0, "clr_exit");
        clr_fault = 1'b0;
        step(20, 12'h000, 1'b0, 1'b0, 1'b0, "post_fault_idle");

        // Top-of-range saturation: 12'hFFE then 12'hFFF with no wrap
        strobe(12'hFFE);
        step(1,     12'h000, 1'b1, 1'b0, 1'b0, "sat_enter");
        step(16368, 12'hFFC, 1'b1, 1'b0, 1'b0, "sat_near");
        step(16,    12'hFFE, 1'b1, 1'b0, 1'b0, "sat_clamp_goal");
        step(1,     12'hFFE, 1'b0, 1'b0, 1'b0, "sat_hold");
        strobe(12'hFFF);
        step(1,     12'hFFE, 1'b1, 1'b0, 1'b0, "sat2_enter");
        step(16,    12'hFFF, 1'b1, 1'b0, 1'b0, "sat2_no_wrap");
        step(1,     12'hFFF, 1'b0, 1'b0, 1'b0, "sat2_hold");

        // Asynchronous reset mid-ramp; nothing resumes afterwards
        strobe(12'h800);
        step(1,  12'hFFF, 1'b1, 1'b0, 1'b0, "rst_ramp_enter");
        step(40, 12'hFF7, 1'b1, 1'b0, 1'b0, "rst_ramp_mid");
        #3;
        rst_n = 1'b0;
        #1;
        step(0, 12'h000, 1'b0, 1'b0, 1'b0, "async_rst");
        #3;
        rst_n = 1'b1;
        step(40, 12'h000, 1'b0, 1'b0, 1'b0, "rst_no_resume");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
